// File: rtl/cs_out_buffer.sv
// ---------------------------------------------------------------------------
// cs_out_buffer
//
// Output stage of the sliding-window approximate-average filter. Consumes the
// filter's Y result one beat per clock, drops the start-up results produced
// while the WINDOW-sample window is still filling, and queues the valid
// results in a first-word-fall-through FIFO that the host drains through a
// valid/ready handshake. Beats lost to a full FIFO set a sticky overflow flag.
//
// Optional feature (compile-time macro CS_OUT_SAT_EN):
//   defined   : stored value is Y clamped to 255; sat_flag goes sticky-high on
//               any push whose Y exceeded 255 (cleared only by reset).
//   undefined : Y is stored unmodified; sat_flag is tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   Y carries a fresh filter result this cycle
//   Y          in   [DW] filter result
//   clr_ovf    in   synchronous clear of the overflow flag (set wins)
//   out_data   out  [DW] head-of-FIFO result (combinational read)
//   out_valid  out  FIFO non-empty
//   out_ready  in   host accepts out_data this cycle
//   count      out  [$clog2(DEPTH+1)] current occupancy
//   full       out  count == DEPTH
//   empty      out  count == 0
//   warm       out  window filled; the next in_valid beat is stored
//   overflow   out  sticky; a warm beat was dropped because the FIFO was full
//   sat_flag   out  sticky saturation flag (see optional feature above)
// ---------------------------------------------------------------------------
module cs_out_buffer #(
    parameter int unsigned DW     = 10,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WINDOW = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DW-1:0]              Y,
    input  logic                       clr_ovf,
    output logic [DW-1:0]              out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       warm,
    output logic                       overflow,
    output logic                       sat_flag
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [WCW-1:0] WCNT_MAX = WCW'(WINDOW - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [WCW-1:0] r_wcnt;
    logic           r_overflow;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic          w_full;
    logic          w_empty;
    logic          w_warm;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;
    logic [DW-1:0] w_wdata;

    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_warm     = (r_wcnt == WCNT_MAX);
    assign w_push_req = in_valid & w_warm;
    assign w_pop      = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;

    // -----------------------------------------------------------------------
    // Stored value / saturation
    // -----------------------------------------------------------------------
`ifdef CS_OUT_SAT_EN
    localparam logic [DW-1:0] SAT_MAX = DW'(255);

    logic w_sat_hit;
    logic r_sat_flag;

    assign w_sat_hit = (Y > SAT_MAX);
    assign w_wdata   = w_sat_hit ? SAT_MAX : Y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_flag <= 1'b0;
        end else if (w_push && w_sat_hit) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    assign w_wdata  = Y;
    assign sat_flag = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Storage (not reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers, occupancy, warm-up counter, overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wcnt     <= '0;
            r_overflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // Start-up beats only advance the counter; it then holds.
            if (in_valid && !w_warm) begin
                r_wcnt <= r_wcnt + WCW'(1);
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = ~w_empty;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign warm      = w_warm;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cs_out_buffer.sv
// ---------------------------------------------------------------------------
// tb_cs_out_buffer
//
// Self-checking bench for cs_out_buffer. Every driven beat is run through a
// small behavioural model; accepted beats push their expected stored value
// onto a queue that is popped and compared whenever the host side pops.
// Honours CS_OUT_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cs_out_buffer;

    localparam int unsigned DW     = 10;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned WINDOW = 9;
    localparam int unsigned CW     = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] Y;
    logic          clr_ovf;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          warm;
    logic          overflow;
    logic          sat_flag;

    cs_out_buffer #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .Y         (Y),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .warm      (warm),
        .overflow  (overflow),
        .sat_flag  (sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model state
    int unsigned q_exp[$];
    int unsigned m_wcnt = 0;
    bit          m_ovf  = 1'b0;
    bit          m_sat  = 1'b0;
    int unsigned n_pops = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned stored_val(input int unsigned y);
`ifdef CS_OUT_SAT_EN
        return (y > 255) ? 255 : y;
`else
        return y;
`endif
    endfunction

    // Evaluate the current inputs against the model, clock once, then
    // compare the registered status outputs 1 ns after the edge.
    task automatic tick();
        bit m_pop;
        bit m_preq;
        bit m_push;
        int unsigned exp_head;
        m_pop  = (q_exp.size() != 0) && out_ready;
        m_preq = in_valid && (m_wcnt == WINDOW - 1);
        m_push = m_preq && ((q_exp.size() < DEPTH) || m_pop);
        check("out_valid_pre", out_valid, (q_exp.size() != 0) ? 1 : 0);
        if (m_pop) begin
            exp_head = q_exp.pop_front();
            check("out_data", out_data, exp_head);
            n_pops++;
        end
        if (m_push) begin
            q_exp.push_back(stored_val(Y));
`ifdef CS_OUT_SAT_EN
            if (Y > 255) m_sat = 1'b1;
`endif
        end
        if (m_preq && (q_exp.size() >= DEPTH) && !m_push) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (in_valid && (m_wcnt < WINDOW - 1)) m_wcnt++;

        @(posedge clk);
        #1;
        check("count", count, q_exp.size());
        check("overflow", overflow, m_ovf);
        check("warm", warm, (m_wcnt == WINDOW - 1) ? 1 : 0);
        check("sat_flag", sat_flag, m_sat);
    endtask

    task automatic drive(input bit v, input int unsigned y, input bit rdy, input bit clr);
        in_valid  = v;
        Y         = DW'(y);
        out_ready = rdy;
        clr_ovf   = clr;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 0, 1'b1, 1'b0);
        check("drained_empty", empty, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        Y         = '0;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_warm", warm, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sat_flag", sat_flag, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Warm-up: 8 beats discarded, 9th stored
        for (int i = 0; i < WINDOW - 1; i++) begin
            check("warmup_warm_before", warm, 0);
            drive(1'b1, 100, 1'b0, 1'b0);
        end
        check("warmup_count0", count, 0);
        check("warmup_warm", warm, 1);
        drive(1'b1, 300, 1'b0, 1'b0);
        check("first_valid", out_valid, 1);
        check("first_data", out_data, stored_val(300));
        check("first_count", count, 1);
        drain();

        // Fill / overflow with no reader
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, i, 1'b0, 1'b0);
            if (i == DEPTH) begin
                check("fill_full", full, 1);
                check("fill_no_ovf_yet", overflow, 0);
            end
            if (i == DEPTH + 1) check("fill_ovf", overflow, 1);
        end
        drain();
        check("fill_empty_count", count, 0);
        drive(1'b0, 0, 1'b0, 1'b1);
        check("ovf_cleared", overflow, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 50 + i, 1'b0, 1'b0);
        check("pp_full", full, 1);
        drive(1'b1, 99, 1'b1, 1'b0);
        check("pp_count", count, DEPTH);
        check("pp_overflow", overflow, 0);
        drain();

        // Wrap-around with toggling ready
        n_pops = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, i, (i % 2) == 0, 1'b0);
            if ((i % 2) == 1) drive(1'b0, 0, 1'b1, 1'b0);
        end
        drain();
        check("wrap_pops", n_pops, 40);
        check("wrap_overflow", overflow, 0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) drive(1'b1, 200 + i, 1'b0, 1'b0);
        check("mid_count5", count, 5);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_warm", warm, 0);
        check("mid_rst_sat", sat_flag, 0);
        q_exp.delete();
        m_wcnt = 0;
        m_ovf  = 1'b0;
        m_sat  = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < WINDOW - 1; i++) drive(1'b1, 7, 1'b0, 1'b0);
        check("rewarm_count0", count, 0);
        check("rewarm_warm", warm, 1);

        // Saturation boundary
        drive(1'b1, 573, 1'b0, 1'b0);
        check("sat_valid", out_valid, 1);
`ifdef CS_OUT_SAT_EN
        check("sat_data", out_data, 255);
        check("sat_flag_set", sat_flag, 1);
`else
        check("sat_data", out_data, 573);
        check("sat_flag_off", sat_flag, 0);
`endif
        drive(1'b1, 255, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
